datapath_ctrl: RTL
==================

# datapath_ctrl

Sequencing controller for the lab datapath (8×16 register file, A/B operand registers, shifter, ALU, C result register, Z status flag). It accepts one register-level instruction through a start/ready handshake. It then drives the datapath control lines state by state through operand load, execute and write-back, and pulses `done` when the instruction retires. It sits between the instruction source (bench or future decoder) and the datapath, and owns every datapath control input.

## Interface
- `IMM_W`, 16: immediate / `datapath_in` width; equals datapath word width.
- `clk` in 1: rising-edge clock shared with the datapath.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: instruction request, accepted only when `ready`=1.
- `op` in 2: 00 MOVI, 01 MOV, 10 ALU, 11 CMP.
- `rd`, `rn`, `rm` in 3 each: destination and source register numbers.
- `sh_in` in 2: shifter code applied to the B operand.
- `aluop_in` in 2: 00 add, 01 sub, 10 and, 11 not-B.
- `imm` in `IMM_W`: MOVI value.
- `ready` out 1: high only in IDLE.
- `done` out 1: one-cycle retire pulse.
- `vsel`, `write`, `writenum[2:0]`, `readnum[2:0]`, `loada`, `loadb`, `loadc`, `loads`, `asel`, `bsel`, `shift[1:0]`, `ALUop[1:0]`, `datapath_in[IMM_W-1:0]` out: datapath controls.
  - `vsel`=1 selects `datapath_in`; `vsel`=0 selects C.
  - `asel`=1 forces the A operand to 0.
  - `bsel`=0 selects the shifter output.

## Operation
- On accept (`start`=1 while `ready`=1), `op`, `rd`, `rn`, `rm`, `sh_in`, `aluop_in` and `imm` are latched. Inputs are ignored for the rest of the instruction.
- States: IDLE, LOADA, LOADB, EXEC, WB, DONE.
- State paths:
  - ALU: LOADA→LOADB→EXEC→WB→DONE.
  - MOV: LOADB→EXEC→WB→DONE.
  - MOVI: WB→DONE.
  - CMP: LOADA→LOADB→EXEC→DONE.
  - DONE→IDLE always.
- Per-state outputs. Any control not listed is 0 in that state; all controls are 0 in IDLE and DONE.
  - LOADA: `readnum`=rn, `loada`=1.
  - LOADB: `readnum`=rm, `loadb`=1.
  - EXEC:
    - Common: `shift`=sh, `bsel`=0, `loadc`=1.
    - `ALUop`: aluop for ALU, 00 for MOV, 01 for CMP.
    - `asel`=1 for MOV, else 0.
    - `loadc`=0 for CMP.
    - `loads`=1 for ALU and CMP.
  - WB:
    - Common: `write`=1, `writenum`=rd.
    - MOVI: `vsel`=1, `datapath_in`=imm.
    - ALU, MOV: `vsel`=0.
- `done`=1 in DONE only.
- All outputs are decoded from the state register and latched fields only; there is no combinational path from any input to any output.
- Reset (any time, including mid-instruction): state IDLE, all datapath controls 0, `done`=0, `ready`=1, latched fields 0. The register file contents are unaffected.
- `start` while busy is dropped, not queued.
- MOV and CMP ignore `rn`; MOVI ignores `rn`, `rm`, `sh_in` and `aluop_in`.

## Timing
- Accept edge = edge 0. The datapath samples each state's controls on the edge that ends that state.
- `done` is high during cycle N after accept:
  - MOVI: N=2.
  - MOV: N=4.
  - CMP: N=4.
  - ALU: N=5.
- `ready` returns high in cycle N+1, so back-to-back throughput is one instruction per N+1 cycles.
- `start` held high continuously re-issues the same instruction, accepted in each IDLE cycle.

## Configuration
- `DATAPATH_CTRL_STATUS_EN`
  - Defined: `loads` is driven as in Operation and CMP executes.
  - Undefined:
    - `loads` is tied 0.
    - CMP goes IDLE→DONE with no datapath activity, so `done` is high in cycle 1.
    - ALU instructions still write back.

## Structure
- Package `datapath_ctrl_pkg` holds:
  - state enum `dpc_state_t`;
  - op constants `OP_MOVI`, `OP_MOV`, `OP_ALU`, `OP_CMP`;
  - ALU constants `ALU_ADD`, `ALU_SUB`, `ALU_AND`, `ALU_NOTB`;
  - shift constants `SH_NONE`, `SH_LSL`, `SH_LSR`, `SH_ASR`.
- One sub-module, `datapath_ctrl_ireg`: the instruction field latch with accept enable and asynchronous clear. The FSM and output decode live in the top.

## Test plan
- MOVI rd=2, imm=202 → `done` in cycle 2; WB cycle shows `vsel`=1, `write`=1, `writenum`=2, `datapath_in`=202; register R2 = 202 afterwards.
- R2=202, R4=51; ALU rd=3, rn=2, rm=4, sh=11, op=sub → LOADA `readnum`=2, LOADB `readnum`=4, EXEC `ALUop`=01 with `loadc`=`loads`=1; R3 = 202−25 = 177; Z=0; `done` in cycle 5.
- R0=7; MOV rd=1, rm=0, sh=01 → no LOADA; EXEC `asel`=1, `ALUop`=00; R1 = 14; `done` in cycle 4.
- R5=6, R7=6; CMP rn=5, rm=7 → `loadc`=0 and no write occurs; Z=1; R-file unchanged. With the macro undefined, `done` is in cycle 1 and `loads` is never asserted.
- `start` pulsed during LOADB of an ALU instruction → ignored; exactly one `done`; next accept occurs only after `ready`=1.
- `reset_n` low during EXEC → all controls 0 immediately; no write to `rd`; `ready`=1 after release; a new MOVI completes normally.

Source files
------------

// File: rtl/datapath_ctrl_pkg.sv
// Shared types and encodings for the datapath sequencing controller.
package datapath_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOADA = 3'd1,
    LOADB = 3'd2,
    EXEC  = 3'd3,
    WB    = 3'd4,
    DONE  = 3'd5
  } dpc_state_t;

  localparam logic [1:0] OP_MOVI = 2'b00;
  localparam logic [1:0] OP_MOV  = 2'b01;
  localparam logic [1:0] OP_ALU  = 2'b10;
  localparam logic [1:0] OP_CMP  = 2'b11;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_AND  = 2'b10;
  localparam logic [1:0] ALU_NOTB = 2'b11;

  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL  = 2'b01;
  localparam logic [1:0] SH_LSR  = 2'b10;
  localparam logic [1:0] SH_ASR  = 2'b11;

endpackage

// File: rtl/datapath_ctrl_ireg.sv
// Instruction field latch: captures the request fields on accept and holds
// them for the whole instruction; cleared by the asynchronous reset.
module datapath_ctrl_ireg #(
  parameter int IMM_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [1:0]       op,
  input  logic [2:0]       rd,
  input  logic [2:0]       rn,
  input  logic [2:0]       rm,
  input  logic [1:0]       sh,
  input  logic [1:0]       aluop,
  input  logic [IMM_W-1:0] imm,
  output logic [1:0]       op_q,
  output logic [2:0]       rd_q,
  output logic [2:0]       rn_q,
  output logic [2:0]       rm_q,
  output logic [1:0]       sh_q,
  output logic [1:0]       aluop_q,
  output logic [IMM_W-1:0] imm_q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q    <= '0;
      rd_q    <= '0;
      rn_q    <= '0;
      rm_q    <= '0;
      sh_q    <= '0;
      aluop_q <= '0;
      imm_q   <= '0;
    end else if (en) begin
      op_q    <= op;
      rd_q    <= rd;
      rn_q    <= rn;
      rm_q    <= rm;
      sh_q    <= sh;
      aluop_q <= aluop;
      imm_q   <= imm;
    end
  end

endmodule

// File: rtl/datapath_ctrl.sv
// Sequencing controller for the lab datapath: one instruction per start/ready
// handshake. Define DATAPATH_CTRL_STATUS_EN to enable the Z-flag load and CMP.
module datapath_ctrl
  import datapath_ctrl_pkg::*;
#(
  parameter int IMM_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [2:0]       rd,
  input  logic [2:0]       rn,
  input  logic [2:0]       rm,
  input  logic [1:0]       sh_in,
  input  logic [1:0]       aluop_in,
  input  logic [IMM_W-1:0] imm,
  output logic             ready,
  output logic             done,
  output logic             vsel,
  output logic             write,
  output logic [2:0]       writenum,
  output logic [2:0]       readnum,
  output logic             loada,
  output logic             loadb,
  output logic             loadc,
  output logic             loads,
  output logic             asel,
  output logic             bsel,
  output logic [1:0]       shift,
  output logic [1:0]       ALUop,
  output logic [IMM_W-1:0] datapath_in
);

  dpc_state_t       state, state_nx;
  logic             accept;
  logic [1:0]       op_q, sh_q, aluop_q;
  logic [2:0]       rd_q, rn_q, rm_q;
  logic [IMM_W-1:0] imm_q;

  assign accept = start && (state == IDLE);

  datapath_ctrl_ireg #(.IMM_W(IMM_W)) u_ireg (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (accept),
    .op      (op),
    .rd      (rd),
    .rn      (rn),
    .rm      (rm),
    .sh      (sh_in),
    .aluop   (aluop_in),
    .imm     (imm),
    .op_q    (op_q),
    .rd_q    (rd_q),
    .rn_q    (rn_q),
    .rm_q    (rm_q),
    .sh_q    (sh_q),
    .aluop_q (aluop_q),
    .imm_q   (imm_q)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Outputs depend only on state and latched fields; raw inputs steer only
  // the IDLE exit.
  always_comb begin
    state_nx    = state;
    ready       = 1'b0;
    done        = 1'b0;
    vsel        = 1'b0;
    write       = 1'b0;
    writenum    = '0;
    readnum     = '0;
    loada       = 1'b0;
    loadb       = 1'b0;
    loadc       = 1'b0;
    loads       = 1'b0;
    asel        = 1'b0;
    bsel        = 1'b0;
    shift       = SH_NONE;
    ALUop       = ALU_ADD;
    datapath_in = '0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          case (op)
            OP_MOVI: state_nx = WB;
            OP_MOV:  state_nx = LOADB;
            OP_ALU:  state_nx = LOADA;
`ifdef DATAPATH_CTRL_STATUS_EN
            default: state_nx = LOADA;
`else
            default: state_nx = DONE;
`endif
          endcase
        end
      end
      LOADA: begin
        readnum  = rn_q;
        loada    = 1'b1;
        state_nx = LOADB;
      end
      LOADB: begin
        readnum  = rm_q;
        loadb    = 1'b1;
        state_nx = EXEC;
      end
      EXEC: begin
        shift = sh_q;
        asel  = (op_q == OP_MOV);
        loadc = (op_q != OP_CMP);
        if (op_q == OP_ALU)      ALUop = aluop_q;
        else if (op_q == OP_CMP) ALUop = ALU_SUB;
`ifdef DATAPATH_CTRL_STATUS_EN
        loads = (op_q == OP_ALU) || (op_q == OP_CMP);
`endif
        state_nx = (op_q == OP_CMP) ? DONE : WB;
      end
      WB: begin
        write    = 1'b1;
        writenum = rd_q;
        if (op_q == OP_MOVI) begin
          vsel        = 1'b1;
          datapath_in = imm_q;
        end
        state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule
